// File: rtl/key_sched_pkg.sv
// Shared constants and state type for the round-key scheduling controller.
package key_sched_pkg;

    localparam int KEY_W      = 128;
    localparam int NR_DEFAULT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/key_update.sv
// Fixed bit permutation that derives the next round key from the current one.
// Pure wiring, no arithmetic: {k[19:0], k[127:36], k[20], k[35:21]}.
module key_update
    import key_sched_pkg::*;
(
    input  logic [KEY_W-1:0] k,
    output logic [KEY_W-1:0] k_next
);

    // Rotate the low 20 bits to the top and swap bit 20 ahead of bits 35:21.
    always_comb begin
        k_next = {k[19:0], k[127:36], k[20], k[35:21]};
    end

endmodule

// File: rtl/key_sched_ctrl.sv
// Round-key sequencer: accepts a master key, then streams NR round keys
// (round 0 is the master key itself) over a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a master key; key_ready=1, rk/rk_round hold last
// RUN   | presenting round key rk_round; advances on each handshake
module key_sched_ctrl
    import key_sched_pkg::*;
#(
    parameter int NR = NR_DEFAULT,
    parameter int RW = $clog2(NR)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             abort,
    output logic [KEY_W-1:0] rk,
    output logic [RW-1:0]    rk_round,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [RW-1:0] LAST_ROUND = RW'(NR - 1);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d, key_nxt;
    logic [RW-1:0]    round_q, round_d;
    logic             done_d;
    logic             rk_valid_q, busy_q, done_q;

    key_update u_key_update (
        .k      (key_q),
        .k_next (key_nxt)
    );

    // Next-state, key register and round counter decisions; abort wins over
    // any handshake or key offer in the same cycle.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid && !abort) begin
                    state_d = RUN;
                    key_d   = key_in;
                    round_d = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rk_ready) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = key_nxt;
                        round_d = round_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            round_q    <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            round_q    <= round_d;
            rk_valid_q <= (state_d == RUN);
            busy_q     <= (state_d == RUN);
            done_q     <= done_d;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign rk        = key_q;
    assign rk_round  = round_q;
    assign rk_valid  = rk_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: a sequence-level reference model (each accepted
// key expands into its full list of NR round keys) checked every cycle, plus
// literal expectations for the key scenarios.
module tb_key_sched_ctrl;

    localparam int NR = 32;
    localparam int RW = $clog2(NR);

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  key_in;
    logic          key_valid;
    logic          key_ready;
    logic          abort;
    logic [127:0]  rk;
    logic [RW-1:0] rk_round;
    logic          rk_valid;
    logic          rk_ready;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit           m_run  = 1'b0;
    bit           m_done = 1'b0;
    int           m_round = 0;
    logic [127:0] m_key = '0;
    logic [127:0] seq [NR];

    key_sched_ctrl #(.NR(NR), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .abort     (abort),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference permutation written as a destination->source index map.
    function automatic logic [127:0] perm_ref(input logic [127:0] k);
        logic [127:0] r;
        int src;
        for (int d = 0; d < 128; d++) begin
            if (d >= 108)      src = d - 108;
            else if (d >= 16)  src = d + 20;
            else if (d == 15)  src = 20;
            else               src = d + 21;
            r[d] = k[src];
        end
        return r;
    endfunction

    // Sequence-level model: on accept, expand the whole round-key list.
    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_done = 1'b0; m_round = 0; m_key = '0;
        end else begin
            m_done = 1'b0;
            if (!m_run) begin
                if (key_valid && !abort) begin
                    seq[0] = key_in;
                    for (int i = 1; i < NR; i++) seq[i] = perm_ref(seq[i-1]);
                    m_run = 1'b1; m_round = 0; m_key = seq[0];
                end
            end else if (abort) begin
                m_run = 1'b0;
            end else if (rk_ready) begin
                if (m_round == NR - 1) begin
                    m_run = 1'b0; m_done = 1'b1;
                end else begin
                    m_round = m_round + 1; m_key = seq[m_round];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && rk_valid && rk_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        if (done === 1'b1) done_cnt++;
        chk("m_rk_valid",  128'(rk_valid),  128'(m_run));
        chk("m_busy",      128'(busy),      128'(m_run));
        chk("m_key_ready", 128'(key_ready), 128'(!m_run));
        chk("m_done",      128'(done),      128'(m_done));
        chk("m_rk",        rk,              m_key);
        chk("m_rk_round",  128'(rk_round),  128'(m_round));
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) check_model();
    endtask

    int hs0, d0;

    initial begin
        rst = 1'b1; key_in = '0; key_valid = 1'b0; abort = 1'b0; rk_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        check_model();
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_rk", rk, 128'd0);
        rst = 1'b0;

        // key 1, rk_ready held: rounds 0,1,2 and a single done after 32 handshakes
        hs0 = hs_cnt; d0 = done_cnt;
        key_in = 128'h1; key_valid = 1'b1; rk_ready = 1'b1;
        step(); key_valid = 1'b0;
        chk("k1_r0_round", 128'(rk_round), 128'd0);
        chk("k1_r0_rk", rk, 128'h1);
        step();
        chk("k1_r1_rk", rk, 128'h1 << 108);
        step();
        chk("k1_r2_rk", rk, 128'h1 << 88);
        chk("k1_r2_round", 128'(rk_round), 128'd2);
        repeat (35) step();
        chk("k1_handshakes", 128'(hs_cnt - hs0), 128'd32);
        chk("k1_done_cycles", 128'(done_cnt - d0), 128'd1);

        // single-bit keys exercising bit 20 and bit 21 routing
        key_in = 128'h1 << 20; key_valid = 1'b1;
        step(); key_valid = 1'b0;
        step();
        chk("b20_r1_rk", rk, 128'h1 << 15);
        abort = 1'b1; step(); abort = 1'b0;
        chk("b20_abort_busy", 128'(busy), 128'd0);
        key_in = 128'h1 << 21; key_valid = 1'b1;
        step(); key_valid = 1'b0;
        step();
        chk("b21_r1_rk", rk, 128'h1);
        abort = 1'b1; step(); abort = 1'b0;

        // random backpressure
        hs0 = hs_cnt; d0 = done_cnt;
        key_in = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210; key_valid = 1'b1; rk_ready = 1'b0;
        step(); key_valid = 1'b0;
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            rk_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("rnd_done_cycles", 128'(done_cnt - d0), 128'd1);
        chk("rnd_handshakes", 128'(hs_cnt - hs0), 128'd32);
        rk_ready = 1'b1;

        // abort at round 5 together with a handshake
        d0 = done_cnt;
        key_in = 128'hdead_beef_0000_1111_2222_3333_4444_5555; key_valid = 1'b1;
        step(); key_valid = 1'b0;
        for (int i = 0; i < 20 && rk_round != 5; i++) step();
        chk("ab_reach_r5", 128'(rk_round), 128'd5);
        abort = 1'b1; step(); abort = 1'b0;
        chk("ab_key_ready", 128'(key_ready), 128'd1);
        chk("ab_busy", 128'(busy), 128'd0);
        chk("ab_no_done", 128'(done_cnt - d0), 128'd0);
        key_in = 128'hA; key_valid = 1'b1;
        step(); key_valid = 1'b0;
        chk("ab_new_round", 128'(rk_round), 128'd0);
        chk("ab_new_rk", rk, 128'hA);
        abort = 1'b1; step(); abort = 1'b0;

        // abort in IDLE blocks a simultaneous key offer
        key_in = 128'h55; key_valid = 1'b1; abort = 1'b1;
        step(); key_valid = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", 128'(busy), 128'd0);

        // reset at round 10 while key_valid is held through RUN
        key_in = 128'hcafe_f00d_1234_5678_9abc_def0_0fed_cba9; key_valid = 1'b1;
        step(); key_in = 128'h7777;
        for (int i = 0; i < 20 && rk_round != 10; i++) step();
        chk("rs_reach_r10", 128'(rk_round), 128'd10);
        rst = 1'b1; step(); rst = 1'b0; key_valid = 1'b0;
        chk("rs_rk_valid", 128'(rk_valid), 128'd0);
        chk("rs_busy", 128'(busy), 128'd0);
        chk("rs_rk", rk, 128'd0);
        chk("rs_round", 128'(rk_round), 128'd0);

        // back-to-back keys with key_valid held
        key_in = 128'h1111_2222_3333_4444_5555_6666_7777_8888; key_valid = 1'b1;
        step(); key_in = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;
        for (int i = 0; i < 50 && done !== 1'b1; i++) step();
        chk("b2b_done", 128'(done), 128'd1);
        step(); key_valid = 1'b0;
        chk("b2b_round", 128'(rk_round), 128'd0);
        chk("b2b_rk", rk, 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001);
        chk("b2b_valid", 128'(rk_valid), 128'd1);
        abort = 1'b1; step(); abort = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
